// File: rtl/fifo_lvl_pkg.sv
// Shared definitions for the level-tracking FIFO: read-mode encodings and the
// per-cycle operation decode used for the level update.
package fifo_lvl_pkg;

  localparam int unsigned FifoModeStd  = 0;
  localparam int unsigned FifoModeFwft = 1;

  // {read accepted, write accepted}
  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpWr   = 2'b01,
    OpRd   = 2'b10,
    OpWrRd = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// The read register only updates on re_i, so read data holds between reads.
module simple_dpram_sclk #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter bit          ENABLE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      // Same-address read-during-write returns the incoming word.
      if (ENABLE_BYPASS && we_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[raddr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_lvl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and selectable FWFT or standard read timing.
module fifo_lvl
  import fifo_lvl_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FWFT        = FifoModeFwft,
  parameter int unsigned AF_THRESH   = (1 << DEPTH_WIDTH) - 1,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_WIDTH:0]  level_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int unsigned Depth = 1 << DEPTH_WIDTH;
  localparam bit          Fwft  = (FWFT == FifoModeFwft);

  typedef logic [DEPTH_WIDTH:0] cnt_t;

  localparam cnt_t One      = cnt_t'(1);
  localparam cnt_t DepthLvl = cnt_t'(Depth);
  localparam cnt_t AfLvl    = cnt_t'(AF_THRESH);
  localparam cnt_t AeLvl    = cnt_t'(AE_THRESH);

  if (DEPTH_WIDTH < 1 || DATA_WIDTH < 1 || AF_THRESH < 1 || AF_THRESH > Depth ||
      AE_THRESH >= Depth) begin : gen_bad_params
    $error("fifo_lvl: parameter out of legal range");
  end

  cnt_t     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d, ram_cnt;
  logic     head_valid_q, head_valid_d, rd_valid_q, rd_valid_d;
  logic     ovf_q, ovf_d, udf_q, udf_d;
  logic     full, empty, wr_acc, rd_acc, ram_re;
  fifo_op_e op;

  always_comb begin
    full    = (level_q == DepthLvl);
    empty   = Fwft ? !head_valid_q : (level_q == '0);
    wr_acc  = wr_en_i & ~full;
    rd_acc  = rd_en_i & ~empty;
    ram_cnt = wr_ptr_q - rd_ptr_q;
    // In FWFT mode the RAM read register is the head word; refill it whenever
    // it is empty or being popped and the RAM still holds words.
    ram_re  = Fwft ? ((ram_cnt != '0) && (!head_valid_q || rd_acc)) : rd_acc;
    op      = fifo_op_e'({rd_acc, wr_acc});

    level_d = level_q;
    unique case (op)
      OpWr:    level_d = level_q + One;
      OpRd:    level_d = level_q - One;
      default: level_d = level_q;
    endcase

    wr_ptr_d     = wr_acc ? (wr_ptr_q + One) : wr_ptr_q;
    rd_ptr_d     = ram_re ? (rd_ptr_q + One) : rd_ptr_q;
    head_valid_d = ram_re ? 1'b1 : (rd_acc ? 1'b0 : head_valid_q);
    rd_valid_d   = rd_acc;
    // A new error event outranks a simultaneous clear.
    ovf_d        = (wr_en_i & full) | (ovf_q & ~clr_err_i);
    udf_d        = (rd_en_i & empty) | (udf_q & ~clr_err_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      rd_valid_q   <= rd_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1'b1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[DEPTH_WIDTH-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[DEPTH_WIDTH-1:0]),
    .rdata_o (rd_data_o)
  );

  always_comb begin
    rd_valid_o     = Fwft ? head_valid_q : rd_valid_q;
    full_o         = full;
    empty_o        = empty;
    almost_full_o  = (level_q >= AfLvl);
    almost_empty_o = (level_q <= AeLvl);
    level_o        = level_q;
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench: one standard-mode and one FWFT-mode fifo_lvl (depth 4, 8-bit),
// with a queue scoreboard for standard-mode read data.
module tb_fifo_lvl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] s_wd, s_rdata;
  logic       s_wr, s_rd, s_clr, s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [2:0] s_lvl;

  logic [7:0] f_wd, f_rdata;
  logic       f_wr, f_rd, f_clr, f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] f_lvl;

  fifo_lvl #(
    .DEPTH_WIDTH (2),
    .DATA_WIDTH  (8),
    .FWFT        (0),
    .AF_THRESH   (3),
    .AE_THRESH   (1)
  ) u_std (
    .clk            (clk),
    .rst            (rst),
    .wr_data_i      (s_wd),
    .wr_en_i        (s_wr),
    .rd_en_i        (s_rd),
    .rd_data_o      (s_rdata),
    .rd_valid_o     (s_rvalid),
    .full_o         (s_full),
    .empty_o        (s_empty),
    .almost_full_o  (s_af),
    .almost_empty_o (s_ae),
    .level_o        (s_lvl),
    .overflow_o     (s_ovf),
    .underflow_o    (s_udf),
    .clr_err_i      (s_clr)
  );

  fifo_lvl #(
    .DEPTH_WIDTH (2),
    .DATA_WIDTH  (8),
    .FWFT        (1),
    .AF_THRESH   (3),
    .AE_THRESH   (1)
  ) u_fwft (
    .clk            (clk),
    .rst            (rst),
    .wr_data_i      (f_wd),
    .wr_en_i        (f_wr),
    .rd_en_i        (f_rd),
    .rd_data_o      (f_rdata),
    .rd_valid_o     (f_rvalid),
    .full_o         (f_full),
    .empty_o        (f_empty),
    .almost_full_o  (f_af),
    .almost_empty_o (f_ae),
    .level_o        (f_lvl),
    .overflow_o     (f_ovf),
    .underflow_o    (f_udf),
    .clr_err_i      (f_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Standard-mode reference model
  int         sm_lvl;
  bit         sm_ovf, sm_udf, sm_rexp;
  logic [7:0] sm_data[$];
  logic [7:0] sm_exp[$];

  task automatic model_reset();
    sm_lvl  = 0;
    sm_ovf  = 1'b0;
    sm_udf  = 1'b0;
    sm_rexp = 1'b0;
    sm_data.delete();
    sm_exp.delete();
  endtask

  task automatic s_cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit wa, ra;
    s_wr  = wr;
    s_wd  = d;
    s_rd  = rd;
    s_clr = clr;
    wa = wr && (sm_lvl != 4);
    ra = rd && (sm_lvl != 0);
    if (ra) sm_exp.push_back(sm_data.pop_front());
    if (wa) sm_data.push_back(d);
    sm_lvl  = sm_lvl + int'(wa) - int'(ra);
    sm_ovf  = (wr && !wa) || (sm_ovf && !clr);
    sm_udf  = (rd && !ra) || (sm_udf && !clr);
    sm_rexp = ra;
    @(posedge clk);
    #1;
    s_wr  = 1'b0;
    s_rd  = 1'b0;
    s_clr = 1'b0;
  endtask

  // Scoreboard: every standard-mode rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && s_rvalid === 1'b1) begin
      n_vec++;
      if (sm_exp.size() == 0) begin
        n_err++;
        $display("FAIL std_scoreboard: unexpected rd_valid, data=%02h", s_rdata);
      end else begin
        logic [7:0] e;
        e = sm_exp.pop_front();
        if (s_rdata !== e) begin
          n_err++;
          $display("FAIL std_scoreboard: rd_data=%02h expected %02h", s_rdata, e);
        end
      end
    end
  end

  task automatic test_reset();
    logic [17:0] exp_v;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_v = {3'd0, 7'b0101000, 8'h00};
    n_vec++;
    if ({s_lvl, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_rvalid, s_rdata} !== exp_v) begin
      n_err++;
      $display("FAIL reset_std: got %05h expected %05h",
               {s_lvl, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_rvalid, s_rdata}, exp_v);
    end
    n_vec++;
    if ({f_lvl, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_rvalid, f_rdata} !== exp_v) begin
      n_err++;
      $display("FAIL reset_fwft: got %05h expected %05h",
               {f_lvl, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_rvalid, f_rdata}, exp_v);
    end
  endtask

  task automatic test_std_fill();
    for (int i = 0; i < 4; i++) begin
      s_cycle(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
      n_vec++;
      if (s_lvl !== 3'(sm_lvl)) begin
        n_err++;
        $display("FAIL fill_level[%0d]: level=%0d expected %0d", i, s_lvl, sm_lvl);
      end
      n_vec++;
      if ({s_full, s_af, s_ae, s_empty} !== {sm_lvl == 4, sm_lvl >= 3, sm_lvl <= 1, sm_lvl == 0})
      begin
        n_err++;
        $display("FAIL fill_flags[%0d]: full/af/ae/empty=%b expected %b", i,
                 {s_full, s_af, s_ae, s_empty},
                 {sm_lvl == 4, sm_lvl >= 3, sm_lvl <= 1, sm_lvl == 0});
      end
    end
    s_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    n_vec++;
    if ({s_ovf, s_lvl} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL overflow: ovf=%b level=%0d expected ovf=1 level=4", s_ovf, s_lvl);
    end
  endtask

  task automatic test_simul();
    // Full: read wins, write of 77 dropped
    s_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    n_vec++;
    if ({s_lvl, s_ovf, s_rvalid} !== {3'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL simul_full: level=%0d ovf=%b rvalid=%b expected 3/1/1", s_lvl, s_ovf,
               s_rvalid);
    end
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b1, 8'h88, 1'b1, 1'b0);
    n_vec++;
    if ({s_lvl, s_rvalid} !== {3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL simul_mid: level=%0d rvalid=%b expected 2/1", s_lvl, s_rvalid);
    end
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if ({s_rvalid, s_rdata} !== {1'b0, 8'hA3}) begin
      n_err++;
      $display("FAIL rdata_hold: rvalid=%b data=%02h expected 0/a3", s_rvalid, s_rdata);
    end
    for (int i = 0; i < 6 && sm_lvl > 0; i++) begin
      s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (s_rvalid !== 1'b1) begin
        n_err++;
        $display("FAIL drain_valid[%0d]: rvalid=%b expected 1", i, s_rvalid);
      end
    end
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if ({s_empty, s_lvl, s_rvalid} !== {1'b1, 3'd0, 1'b0} || sm_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain_empty: empty=%b level=%0d rvalid=%b pending=%0d expected 1/0/0/0",
               s_empty, s_lvl, s_rvalid, sm_exp.size());
    end
  endtask

  task automatic test_errors();
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++;
    if ({s_udf, s_rvalid} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL underflow: udf=%b rvalid=%b expected 1/0", s_udf, s_rvalid);
    end
    s_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    n_vec++;
    if ({s_udf, s_ovf} !== {sm_udf, sm_ovf}) begin
      n_err++;
      $display("FAIL clr_vs_set: udf/ovf=%b%b expected %b%b", s_udf, s_ovf, sm_udf, sm_ovf);
    end
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_vec++;
    if ({s_udf, s_ovf} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_only: udf/ovf=%b%b expected 00", s_udf, s_ovf);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
      n_vec++;
      if (s_lvl !== 3'd1) begin
        n_err++;
        $display("FAIL wrap_wr[%0d]: level=%0d expected 1", i, s_lvl);
      end
      s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if ({s_lvl, s_rvalid, s_rdata} !== {3'd0, 1'b1, 8'(i)}) begin
        n_err++;
        $display("FAIL wrap_rd[%0d]: level=%0d rvalid=%b data=%02h expected 0/1/%02h", i,
                 s_lvl, s_rvalid, s_rdata, 8'(i));
      end
    end
  endtask

  task automatic test_fwft_fall();
    f_wr = 1'b1;
    f_wd = 8'h5C;
    @(posedge clk);
    #1;
    f_wr = 1'b0;
    n_vec++;
    if ({f_lvl, f_empty} !== {3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL fwft_c1: level=%0d empty=%b expected 1/1", f_lvl, f_empty);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({f_rdata, f_empty, f_rvalid} !== {8'h5C, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL fwft_c2: data=%02h empty=%b rvalid=%b expected 5c/0/1", f_rdata, f_empty,
               f_rvalid);
    end
    f_rd = 1'b1;
    @(posedge clk);
    #1;
    f_rd = 1'b0;
    n_vec++;
    if ({f_empty, f_lvl, f_rvalid, f_udf} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fwft_pop: empty=%b level=%0d rvalid=%b udf=%b expected 1/0/0/0", f_empty,
               f_lvl, f_rvalid, f_udf);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fq[$];
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      f_wr = 1'b1;
      f_wd = 8'(8'h10 + i);
      fq.push_back(f_wd);
      @(posedge clk);
      #1;
    end
    f_wr = 1'b0;
    n_vec++;
    if (f_lvl !== 3'd3) begin
      n_err++;
      $display("FAIL b2b_level: level=%0d expected 3", f_lvl);
    end
    for (int k = 0; k < 3; k++) begin
      e = fq.pop_front();
      n_vec++;
      if ({f_empty, f_rdata} !== {1'b0, e}) begin
        n_err++;
        $display("FAIL b2b_pop[%0d]: empty=%b data=%02h expected 0/%02h", k, f_empty, f_rdata,
                 e);
      end
      f_rd = 1'b1;
      @(posedge clk);
      #1;
      f_rd = 1'b0;
    end
    n_vec++;
    if ({f_empty, f_lvl, f_udf, f_ovf} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_end: empty=%b level=%0d udf=%b ovf=%b expected 1/0/0/0", f_empty,
               f_lvl, f_udf, f_ovf);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp_v;
    s_cycle(1'b1, 8'h31, 1'b0, 1'b0);
    s_cycle(1'b1, 8'h32, 1'b0, 1'b0);
    s_cycle(1'b1, 8'h33, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b1, 8'h34, 1'b0, 1'b0);
    n_vec++;
    if (s_lvl !== 3'd3) begin
      n_err++;
      $display("FAIL pre_reset_level: level=%0d expected 3", s_lvl);
    end
    // Reset must win over a concurrent write and read.
    rst  = 1'b1;
    s_wr = 1'b1;
    s_rd = 1'b1;
    s_wd = 8'hEE;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    s_wr = 1'b0;
    s_rd = 1'b0;
    model_reset();
    exp_v = {3'd0, 7'b0101000, 8'h00};
    n_vec++;
    if ({s_lvl, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_rvalid, s_rdata} !== exp_v) begin
      n_err++;
      $display("FAIL mid_reset: got %05h expected %05h",
               {s_lvl, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_rvalid, s_rdata}, exp_v);
    end
    s_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++;
    if ({s_rvalid, s_rdata, s_lvl} !== {1'b1, 8'h99, 3'd0}) begin
      n_err++;
      $display("FAIL post_reset_rd: rvalid=%b data=%02h level=%0d expected 1/99/0", s_rvalid,
               s_rdata, s_lvl);
    end
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if (s_empty !== 1'b1 || sm_exp.size() != 0) begin
      n_err++;
      $display("FAIL post_reset_empty: empty=%b pending=%0d expected 1/0", s_empty,
               sm_exp.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    s_wr  = 1'b0;
    s_rd  = 1'b0;
    s_clr = 1'b0;
    s_wd  = 8'h00;
    f_wr  = 1'b0;
    f_rd  = 1'b0;
    f_clr = 1'b0;
    f_wd  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_std_fill();
    test_simul();
    test_errors();
    test_wrap();
    test_fwft_fall();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
- Parametrised single-clock FIFO, successor to the team's basic store-buffer FIFO.
- Adds:
  - selectable first-word-fall-through (FWFT) or standard read mode;
  - an occupancy count output;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags with a clear input.
- Sits between the SAR ADC sample path and the bus/readout logic to buffer conversion results.

Parameters:
- DEPTH_WIDTH, 4: log2 of capacity; capacity DEPTH = 2**DEPTH_WIDTH; minimum 1.
- DATA_WIDTH, 16: word width; minimum 1.
- FWFT, 1: 1 = head word presented without a read request; 0 = standard one-cycle read latency.
- AF_THRESH, DEPTH-1: almost_full_o asserts when level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserts when level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- wr_data_i  in  DATA_WIDTH  Write data.
- wr_en_i  in  1  Write request.
- rd_en_i  in  1  Read request; in FWFT mode this is the pop of the head word.
- rd_data_o  out  DATA_WIDTH  Read data.
- rd_valid_o  out  1  Standard mode: pulses with returned data. FWFT mode: equals !empty_o.
- full_o  out  1  level == DEPTH.
- empty_o  out  1  No readable word.
- almost_full_o  out  1  level >= AF_THRESH.
- almost_empty_o  out  1  level <= AE_THRESH.
- level_o  out  DEPTH_WIDTH+1  Words held, range 0..DEPTH.
- overflow_o  out  1  Sticky: a write was attempted while full.
- underflow_o  out  1  Sticky: a read was attempted while empty.
- clr_err_i  in  1  Clears both sticky flags.

Behaviour:
- Reset values:
  - pointers = 0, level_o = 0;
  - full_o = 0, empty_o = 1, almost_full_o = 0, almost_empty_o = 1;
  - overflow_o = 0, underflow_o = 0, rd_valid_o = 0, rd_data_o = 0.
- rst has priority over every other input, including mid-transfer; all buffered data is discarded.
- Acceptance is decided from the flags registered at the start of the cycle:
  - write accepted iff wr_en_i & !full_o;
  - read accepted iff rd_en_i & !empty_o.
- Simultaneous read and write:
  - both accepted → level unchanged;
  - when full, the read is accepted and the write is rejected;
  - when empty, the write is accepted and the read is rejected.
- Level update: +1 on write only, -1 on read only, otherwise unchanged.
- Pointers are DEPTH_WIDTH+1 bits and wrap modulo 2*DEPTH.
- Rejected write: data dropped, overflow_o set next cycle. Rejected read: underflow_o set next cycle.
- Sticky flags: clr_err_i clears them; a set event in the same cycle as clr_err_i wins.
- Standard mode (FWFT=0):
  - empty_o = (level == 0);
  - a word written in cycle N is readable from cycle N+1;
  - a read accepted in cycle N gives rd_data_o and a 1-cycle rd_valid_o pulse in cycle N+1;
  - rd_data_o holds its value until the next accepted read.
- FWFT mode (FWFT=1):
  - a one-entry output register holds the head word; empty_o = !head_valid;
  - write to an empty FIFO in cycle N: level_o = 1 at N+1; rd_data_o valid and empty_o = 0 at N+2;
  - pop in cycle N: the next word appears at N+1 if RAM is non-empty, otherwise empty_o = 1 at N+1;
  - level_o counts RAM words plus the head register; total capacity is exactly DEPTH.
- RAM read-during-write to the same address returns the new data (bypass enabled).
- Almost-full/empty flags are decoded from the level register; there is no combinational path from any input to any output.

Decomposition:
- fifo_defs.vh holds:
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - the elaboration-time parameter range checks (translate_off $display warnings, clamping to minimum widths).
- Storage is one instance of the existing simple_dpram_sclk (ADDR_WIDTH = DEPTH_WIDTH, ENABLE_BYPASS = 1).
- Control, level, flags and the FWFT head register live in fifo_lvl itself.

Test Plan:
- All scenarios use DEPTH_WIDTH=2, DATA_WIDTH=8.
- FWFT=0:
  - write A1, A2, A3, A4 → full_o = 1, level_o = 4, almost_full_o = 1 from level 3;
  - a 5th write of FF → overflow_o = 1, level stays 4;
  - 4 reads → A1..A4 each one cycle after its rd_en_i, then empty_o = 1.
- FWFT=1, empty FIFO:
  - write 5C in cycle 0 → level_o = 1 in cycle 1; rd_data_o = 5C and empty_o = 0 in cycle 2;
  - pop → empty_o = 1 the next cycle.
- Full FIFO, simultaneous wr_en_i (data 77) and rd_en_i:
  - read returns the oldest word, write is dropped, overflow_o = 1, level 4 → 3.
  - Repeat with level 2: both accepted, level stays 2, order preserved.
- Empty FIFO, rd_en_i alone → underflow_o = 1.
  - clr_err_i in the same cycle as a new underflow → flag stays 1.
  - clr_err_i alone → flag 0.
- Wrap-around: 10 interleaved write/read pairs with data 00..09 → read order 00..09, pointers wrap, level never exceeds 1.
- Assert rst with level 3 → next cycle level_o = 0, empty_o = 1, all flags at reset values; the following write/read returns the new data only.
